// File: rtl/program_store.sv
// program_store: writable program memory with NOP self-clear, loader port and fetch port.
// Optional per-word even parity with sticky error flag: define PROG_STORE_PARITY_EN.
module program_store #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  fetch_stall,
  input  logic                  load_req,
  input  logic                  load_done,
  input  logic                  clear_req,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic [1:0]            state,
  output logic                  parity_err
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LCNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
`ifdef PROG_STORE_PARITY_EN
  localparam int unsigned MW = DATA_WIDTH + 1;
`else
  localparam int unsigned MW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_RUN   = 2'b01,
    S_LOAD  = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   lcnt_q, lcnt_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
  logic                  fvalid_q, fvalid_d;

  logic [MW-1:0]         mem_q [DEPTH];
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [MW-1:0]         wword;
  logic [MW-1:0]         rword;

  logic in_clear, in_run, in_load;
  logic wr_fire, rd_fire, clr_entry;

  assign in_clear  = (state_q == S_CLEAR);
  assign in_run    = (state_q == S_RUN);
  assign in_load   = (state_q == S_LOAD);
  assign wr_fire   = in_load & wr_valid;
  assign rd_fire   = in_run & fetch_en;
  assign clr_entry = !in_clear && (state_d == S_CLEAR);
  assign rword     = mem_q[fetch_addr];

  // Priority: clear_req > load_done > load_req
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clear_req) begin
          cnt_d = '0;
        end else if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (load_req) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (load_done) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lcnt_d = lcnt_q;
    if (in_run && state_d == S_LOAD) begin
      lcnt_d = '0;
    end else if (wr_fire && lcnt_q != LCNT_MAX) begin
      lcnt_d = lcnt_q + 1'b1;
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = wr_data;
    if (in_clear) begin
      we    = 1'b1;
      waddr = cnt_q;
      wdata = NOP_WORD;
    end else if (wr_fire) begin
      we = 1'b1;
    end
  end

`ifdef PROG_STORE_PARITY_EN
  assign wword = {^wdata, wdata};
`else
  assign wword = wdata;
`endif

  always_comb begin
    fdata_d  = fdata_q;
    fvalid_d = rd_fire;
    if (rd_fire) begin
      fdata_d = rword[DATA_WIDTH-1:0];
    end
  end

  // Array is deliberately not reset; CLEAR defines its contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wword;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      lcnt_q   <= '0;
      fdata_q  <= NOP_WORD;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lcnt_q   <= lcnt_d;
      fdata_q  <= fdata_d;
      fvalid_q <= fvalid_d;
    end
  end

`ifdef PROG_STORE_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (clr_entry) begin
      perr_d = 1'b0;
    end else if (rd_fire && (^rword)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  logic unused_clr_entry;
  assign unused_clr_entry = clr_entry;
  assign parity_err       = 1'b0;
`endif

  assign fetch_data  = fdata_q;
  assign fetch_valid = fvalid_q;
  assign fetch_stall = !in_run;
  assign wr_ready    = in_load;
  assign load_count  = lcnt_q;
  assign state       = state_q;

endmodule
